// File: rtl/state_loader_pkg.sv
// state_loader_pkg -- shared sizing and state encodings for the slice loader.
//
// The ISA_V block below holds the shared ISA header definitions (geometry
// macros and state codes). It is guarded so that when the real shared ISA
// header is compiled first, its definitions are the ones in force and
// nothing here overrides them.
//
// Package contents:
//   NUM_ROW, NUM_LANE, NUM_SLICE, NUM_CELLS  geometry taken from the macros
//   CNT_W, LAST_BEAT                         beat counter sizing
//   ld_state_e                               loader FSM states
`ifndef ISA_V
`define ISA_V
`define NUM_ROW   5
`define NUM_LANE  64
`define NUM_SLICE 25
`define NUM_CELLS 1600
`define ST_LOAD   2'd0
`define ST_FIRE   2'd1
`define ST_WAIT   2'd2
`endif

package state_loader_pkg;
  localparam int NUM_ROW   = `NUM_ROW;
  localparam int NUM_LANE  = `NUM_LANE;
  localparam int NUM_SLICE = `NUM_SLICE;
  localparam int NUM_CELLS = `NUM_CELLS;

  // One beat per lane; the counter wraps naturally on the last beat.
  localparam int                CNT_W     = $clog2(NUM_LANE);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NUM_LANE - 1);

  typedef enum logic [1:0] {
    S_LOAD = `ST_LOAD,
    S_FIRE = `ST_FIRE,
    S_WAIT = `ST_WAIT
  } ld_state_e;
endpackage

// File: rtl/slice_parity.sv
// slice_parity -- even-parity checker for one incoming slice.
// Present only when SLICE_PARITY_EN is defined.
//
// Ports:
//   slice_in  slice payload
//   slice_par even parity bit sent alongside the slice
//   mismatch  1 when the ones count over {slice_in, slice_par} is odd
`ifdef SLICE_PARITY_EN
module slice_parity #(
  parameter int W = 25
) (
  input  logic [W-1:0] slice_in,
  input  logic         slice_par,
  output logic         mismatch
);
  assign mismatch = ^{slice_in, slice_par};
endmodule
`endif

// File: rtl/state_loader.sv
// state_loader -- gathers NUM_LANE slices into one NUM_CELLS-bit state,
// fires the downstream encoder, and waits for it to finish.
//
// Optional feature: define SLICE_PARITY_EN to add slice_par / par_err and
// the slice_parity checker.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   slice_in     one 5x5 slice, rows concatenated MSB-first
//   slice_valid  slice_in valid this cycle
//   slice_ready  loader accepts a slice this cycle (LOAD only)
//   enc_start    one-cycle start pulse to the encoder (FIRE)
//   enc_done     encoder finished; only looked at in WAIT
//   data_out     assembled state, first slice ends up in the MSBs
//   busy         high in FIRE and WAIT
//   slice_par    (SLICE_PARITY_EN) even parity over slice_in
//   par_err      (SLICE_PARITY_EN) sticky parity error, cleared by reset
module state_loader
  import state_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SLICE-1:0] slice_in,
  input  logic                 slice_valid,
  output logic                 slice_ready,
  output logic                 enc_start,
  input  logic                 enc_done,
  output logic [NUM_CELLS-1:0] data_out,
  output logic                 busy
`ifdef SLICE_PARITY_EN
  ,
  input  logic                 slice_par,
  output logic                 par_err
`endif
);

  ld_state_e        state;
  logic [CNT_W-1:0] beat_cnt;
  logic             accept;

  // slice_ready is a register that only mirrors "in LOAD", so this is safe
  // to use as the accept qualifier without a comb path from slice_valid.
  assign accept = slice_valid & slice_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_LOAD;
      beat_cnt    <= '0;
      data_out    <= '0;
      enc_start   <= 1'b0;
      busy        <= 1'b0;
      slice_ready <= 1'b0;
    end else begin
      enc_start <= 1'b0;
      case (state)
        S_LOAD: begin
          // Ready rises on the first edge out of reset and stays up in LOAD.
          slice_ready <= 1'b1;
          if (accept) begin
            data_out <= {data_out[NUM_CELLS-NUM_SLICE-1:0], slice_in};
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state       <= S_FIRE;
              enc_start   <= 1'b1;
              busy        <= 1'b1;
              slice_ready <= 1'b0;
            end
          end
        end
        S_FIRE: state <= S_WAIT;
        S_WAIT: begin
          if (enc_done) begin
            state       <= S_LOAD;
            busy        <= 1'b0;
            slice_ready <= 1'b1;
          end
        end
        default: begin
          state       <= S_LOAD;
          busy        <= 1'b0;
          slice_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef SLICE_PARITY_EN
  logic par_mismatch;

  slice_parity #(.W(NUM_SLICE)) u_slice_parity (
    .slice_in  (slice_in),
    .slice_par (slice_par),
    .mismatch  (par_mismatch)
  );

  // Sticky: only reset clears it; loading is never held up by it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        par_err <= 1'b0;
    else if (accept && par_mismatch) par_err <= 1'b1;
  end
`endif

endmodule

// File: doc/state_loader.md
STATE_LOADER -- requirements
Module: state_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port slice_in, input, `NUM_SLICE bits (25): one 5x5 slice, rows concatenated MSB-first.
REQ-004 SHALL have port slice_valid, input, 1 bit: slice_in is valid this cycle.
REQ-005 SHALL have port slice_ready, output, 1 bit: loader accepts a slice this cycle.
REQ-006 SHALL have port enc_start, output, 1 bit: start pulse to the downstream Encoder.
REQ-007 SHALL have port enc_done, input, 1 bit: done from the Encoder.
REQ-008 SHALL have port data_out, output, `NUM_CELLS bits (1600): assembled state, wired to Encoder data_in.
REQ-009 SHALL have port busy, output, 1 bit: high in FIRE and WAIT.

Function
REQ-010 SHALL implement states LOAD, FIRE, WAIT.
REQ-011 In LOAD: slice_ready=1; a beat is accepted when slice_valid && slice_ready.
REQ-012 On accept, data_out SHALL shift left by 25 and slice_in SHALL enter bits [24:0]; after 64 beats, the first slice occupies [1599:1575].
REQ-013 A 6-bit counter SHALL count accepted beats and wrap 63->0 on the 64th accept.
REQ-014 The 64th accept SHALL move LOAD->FIRE; enc_start SHALL be 1 for exactly the one FIRE cycle; FIRE->WAIT unconditionally.
REQ-015 In FIRE and WAIT: slice_ready=0; data_out SHALL hold stable; slice_valid SHALL be ignored.
REQ-016 WAIT SHALL sample enc_done from the first WAIT cycle; enc_done=1 moves WAIT->LOAD, and slice_ready=1 the next cycle.
REQ-017 enc_done SHALL be ignored in LOAD and FIRE.
REQ-018 data_out SHALL not be cleared on return to LOAD; it is overwritten by shifting only.
REQ-019 Latency SHALL be as follows: enc_start asserts in the cycle after the 64th accept; minimum block-to-block period is 64 + 1 + 1 + (encoder time) cycles.

Reset
REQ-020 While rst=0: state=LOAD, counter=0, data_out=0, enc_start=0, busy=0, slice_ready=0.
REQ-021 slice_ready SHALL assert in the first cycle after rst deasserts.
REQ-022 Reset mid-block SHALL discard the partial slice count and any pending FIRE/WAIT immediately, with no enc_start emitted.

Configuration
REQ-023 With SLICE_PARITY_EN defined, the block SHALL add input slice_par (1 bit, even parity over slice_in) and output par_err (1 bit).
REQ-024 With SLICE_PARITY_EN defined, par_err SHALL set on any accepted beat whose parity mismatches and SHALL stay set until reset; loading proceeds unaffected.
REQ-025 Without SLICE_PARITY_EN, slice_par, par_err and all parity logic SHALL be absent.

Structure
REQ-026 `NUM_ROW (5), `NUM_LANE (64), `NUM_SLICE (25) and `NUM_CELLS (1600) SHALL come from the shared ISA.v header; no local redefinition.
REQ-027 The state encodings SHALL be defined in ISA.v.
REQ-028 The parity check SHALL be a sub-module slice_parity, instantiated only under SLICE_PARITY_EN.

Verification
REQ-029 Scenario: 64 beats with slice_valid held high, slice k = k (mod 2^25) -> enc_start pulses once at cycle 65; data_out[1599:1575]=0 and data_out[24:0]=63.
REQ-030 Scenario: slice_valid toggled 1/0 every cycle -> exactly 64 accepts before FIRE; no enc_start before the 64th accept.
REQ-031 Scenario: hold enc_done=0 for 100 cycles in WAIT while slice_valid=1 -> slice_ready=0 and data_out unchanged throughout; enc_done=1 -> slice_ready=1 the next cycle.
REQ-032 Scenario: drive the 5x5x64 Encoder bench pattern through the loader into the Encoder -> Encoder data_in matches the bench's 1600-bit constant bit-exactly at enc_start.
REQ-033 Scenario: assert rst=0 after 30 beats, then load 64 beats -> exactly one enc_start, and data_out holds only post-reset slices.
REQ-034 Scenario (SLICE_PARITY_EN): beat 10 with wrong slice_par -> par_err=1 from the next cycle until reset; enc_start timing unchanged.
